// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the core-side sram-like memory channels.
package core_mem_pkg;

    localparam int SIZE_W   = 2;
    localparam int MAX_BE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } chan_state_t;

    // Byte enables are contiguous and naturally aligned, so the popcount alone gives log2(bytes).
    function automatic logic [SIZE_W-1:0] be2size(input logic [MAX_BE_W-1:0] be);
        logic [3:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_BE_W; i++) begin
            ones = ones + {3'b000, be[i]};
        end
        case (ones)
            4'd8:    return 2'd3;
            4'd4:    return 2'd2;
            4'd2:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/core_sram_like_bridge_if.sv
// One sram-like request/response port; master is the bridge side, slave is the memory side.
interface core_sram_like_bridge_if
    import core_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addrOk;
    logic              dataOk;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addrOk, dataOk, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addrOk, dataOk, rdata
    );
endinterface

// File: rtl/sram_like_chan.sv
// Purpose: one enable/stall to sram-like channel with response hold until the pipeline advances.
// Latency: req in the same cycle as en; stall drops combinationally in the data_ok cycle.
// Backpressure: stall stays high until data_ok; a held response is kept while longestStall is high.
module sram_like_chan
    import core_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter bit HOLD_RD = 1'b1,
    parameter int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              longestStall,
    input  logic              en,
    input  logic              wr,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cancel,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    core_sram_like_bridge_if.master mem
);

    chan_state_t          st;
    logic                 doneQ;
    logic                 req;
    logic                 accept;
    logic                 complete;
    logic                 keep;
    logic [MAX_BE_W-1:0]  beExt;

    always_comb begin
        beExt = '0;
        beExt[BE_W-1:0] = be;
    end

    assign req      = (st == IDLE) && en && !doneQ;
    assign accept   = req && mem.addrOk;
    // data_ok only counts as a response in WAIT or in the accept cycle; a stray one in IDLE is ignored.
    assign complete = ((st == WAIT) || accept) && mem.dataOk;
    assign keep     = complete && !cancel;

    assign mem.req   = req;
    assign mem.wr    = wr;
    assign mem.size  = be2size(beExt);
    assign mem.addr  = addr;
    assign mem.wdata = wdata;

    assign stall = en && !(doneQ || complete);

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            doneQ <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (accept && !mem.dataOk) begin
                        st <= cancel ? DISCARD : WAIT;
                    end
                end
                WAIT: begin
                    if (mem.dataOk) begin
                        st <= IDLE;
                    end else if (cancel) begin
                        st <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem.dataOk) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase

            // A completion is only remembered if the pipeline cannot consume it this cycle.
            if (cancel) begin
                doneQ <= 1'b0;
            end else if (keep && longestStall) begin
                doneQ <= 1'b1;
            end else if (!longestStall) begin
                doneQ <= 1'b0;
            end
        end
    end

    if (HOLD_RD) begin : gHold
        logic [DATA_W-1:0] rdBuf;

        always_ff @(posedge clk) begin
            if (rst) begin
                rdBuf <= '0;
            end else if (keep) begin
                rdBuf <= mem.rdata;
            end
        end

        assign rdata = doneQ ? rdBuf : mem.rdata;
    end else begin : gPass
        assign rdata = mem.rdata;
    end

endmodule

// File: rtl/core_sram_like_bridge.sv
// Purpose: adapts the core's instruction and data enable/stall ports to two sram-like masters.
// Latency: requests issue in the en cycle; minimum stall is zero extra cycles when addr_ok and data_ok coincide.
// Backpressure: each channel raises its stall until its response arrives; responses are held across longest_stall.
module core_sram_like_bridge
    import core_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter bit HOLD_RD = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                longest_stall,

    input  logic                cpu_inst_en,
    input  logic [ADDR_W-1:0]   cpu_inst_addr,
    input  logic                cpu_inst_cancel,
    output logic [DATA_W-1:0]   cpu_inst_rdata,
    output logic                cpu_inst_stall,

    input  logic                cpu_data_en,
    input  logic                cpu_data_wr,
    input  logic [DATA_W/8-1:0] cpu_data_be,
    input  logic [ADDR_W-1:0]   cpu_data_addr,
    input  logic [DATA_W-1:0]   cpu_data_wdata,
    output logic [DATA_W-1:0]   cpu_data_rdata,
    output logic                cpu_data_stall,

    core_sram_like_bridge_if.master memInst,
    core_sram_like_bridge_if.master memData
);

    localparam int BE_W = DATA_W / 8;

    // Fetches are always full-width reads and may be flushed.
    sram_like_chan #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .HOLD_RD (HOLD_RD)
    ) uInstChan (
        .clk          (clk),
        .rst          (rst),
        .longestStall (longest_stall),
        .en           (cpu_inst_en),
        .wr           (1'b0),
        .be           ({BE_W{1'b1}}),
        .addr         (cpu_inst_addr),
        .wdata        ({DATA_W{1'b0}}),
        .cancel       (cpu_inst_cancel),
        .rdata        (cpu_inst_rdata),
        .stall        (cpu_inst_stall),
        .mem          (memInst)
    );

    sram_like_chan #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .HOLD_RD (HOLD_RD)
    ) uDataChan (
        .clk          (clk),
        .rst          (rst),
        .longestStall (longest_stall),
        .en           (cpu_data_en),
        .wr           (cpu_data_wr),
        .be           (cpu_data_be),
        .addr         (cpu_data_addr),
        .wdata        (cpu_data_wdata),
        .cancel       (1'b0),
        .rdata        (cpu_data_rdata),
        .stall        (cpu_data_stall),
        .mem          (memData)
    );

endmodule

// File: tb/tb_core_sram_like_bridge.sv
// Directed bench for core_sram_like_bridge with a transaction-level reference model checked every cycle.
module tb_core_sram_like_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        longestStall;
    logic        instEn, instCancel, instStall;
    logic [31:0] instAddr, instRdata;
    logic        dataEn, dataWr, dataStall;
    logic [3:0]  dataBe;
    logic [31:0] dataAddr, dataWdata, dataRdata;

    logic        i64En, i64Cancel, i64Stall;
    logic [31:0] i64Addr;
    logic [63:0] i64Rdata;
    logic        d64En, d64Wr, d64Stall;
    logic [7:0]  d64Be;
    logic [31:0] d64Addr;
    logic [63:0] d64Wdata, d64Rdata;

    core_sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) memInst ();
    core_sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) memData ();
    core_sram_like_bridge_if #(.ADDR_W(32), .DATA_W(64)) memInst64 ();
    core_sram_like_bridge_if #(.ADDR_W(32), .DATA_W(64)) memData64 ();

    core_sram_like_bridge dut (
        .clk(clk), .rst(rst), .longest_stall(longestStall),
        .cpu_inst_en(instEn), .cpu_inst_addr(instAddr), .cpu_inst_cancel(instCancel),
        .cpu_inst_rdata(instRdata), .cpu_inst_stall(instStall),
        .cpu_data_en(dataEn), .cpu_data_wr(dataWr), .cpu_data_be(dataBe),
        .cpu_data_addr(dataAddr), .cpu_data_wdata(dataWdata),
        .cpu_data_rdata(dataRdata), .cpu_data_stall(dataStall),
        .memInst(memInst), .memData(memData)
    );

    core_sram_like_bridge #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .longest_stall(longestStall),
        .cpu_inst_en(i64En), .cpu_inst_addr(i64Addr), .cpu_inst_cancel(i64Cancel),
        .cpu_inst_rdata(i64Rdata), .cpu_inst_stall(i64Stall),
        .cpu_data_en(d64En), .cpu_data_wr(d64Wr), .cpu_data_be(d64Be),
        .cpu_data_addr(d64Addr), .cpu_data_wdata(d64Wdata),
        .cpu_data_rdata(d64Rdata), .cpu_data_stall(d64Stall),
        .memInst(memInst64), .memData(memData64)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instMem(input logic aOk, input logic dOk, input logic [31:0] rd);
        memInst.addrOk = aOk;
        memInst.dataOk = dOk;
        memInst.rdata  = rd;
    endtask

    task automatic dataMem(input logic aOk, input logic dOk, input logic [31:0] rd);
        memData.addrOk = aOk;
        memData.dataOk = dOk;
        memData.rdata  = rd;
    endtask

    // Reference model: per channel, an outstanding accepted request (possibly flushed)
    // and a delivered-but-not-yet-consumed response.
    bit          mBusy    [2];
    bit          mFlushed [2];
    bit          mHave    [2];
    logic [31:0] mHeld    [2];

    task automatic modelStep(input int ch);
        logic        en, cnc, aOk, dOk, dReq, dStall, dWr, expWr;
        logic        expReq, acc, resp, expStall, got;
        logic [31:0] mRd, dRd, dAddr, cAddr, dWdata, cWdata;
        logic [1:0]  dSize, expSize;
        string       nm;
        if (ch == 0) begin
            nm = "inst"; en = instEn; cnc = instCancel;
            aOk = memInst.addrOk; dOk = memInst.dataOk; mRd = memInst.rdata;
            dReq = memInst.req; dStall = instStall; dRd = instRdata; dWr = memInst.wr;
            dAddr = memInst.addr; cAddr = instAddr; dSize = memInst.size;
            dWdata = 32'h0; cWdata = 32'h0; expSize = 2'd2; expWr = 1'b0;
        end else begin
            nm = "data"; en = dataEn; cnc = 1'b0;
            aOk = memData.addrOk; dOk = memData.dataOk; mRd = memData.rdata;
            dReq = memData.req; dStall = dataStall; dRd = dataRdata; dWr = memData.wr;
            dAddr = memData.addr; cAddr = dataAddr; dSize = memData.size;
            dWdata = memData.wdata; cWdata = dataWdata;
            expSize = 2'($clog2($countones(dataBe))); expWr = dataWr;
        end

        expReq   = en && !mBusy[ch] && !mHave[ch];
        acc      = expReq && aOk;
        resp     = dOk && ((mBusy[ch] && !mFlushed[ch]) || acc);
        expStall = en && !(mHave[ch] || resp);

        check({nm, "_req"}, dReq, expReq);
        check({nm, "_stall"}, dStall, expStall);
        if (en && !expStall) check({nm, "_rdata"}, dRd, mHave[ch] ? mHeld[ch] : mRd);
        if (expReq) begin
            check({nm, "_addr"}, dAddr, cAddr);
            check({nm, "_wr"}, dWr, expWr);
            check({nm, "_size"}, dSize, expSize);
            if (expWr) check({nm, "_wdata"}, dWdata, cWdata);
        end

        got = resp && !cnc;
        if (got) mHeld[ch] = mRd;
        if (mBusy[ch] && dOk) begin
            mBusy[ch] = 1'b0;
            mFlushed[ch] = 1'b0;
        end else if (mBusy[ch] && cnc) begin
            mFlushed[ch] = 1'b1;
        end
        if (acc && !dOk) begin
            mBusy[ch] = 1'b1;
            mFlushed[ch] = cnc;
        end
        if (cnc) mHave[ch] = 1'b0;
        else if (got && longestStall) mHave[ch] = 1'b1;
        else if (!longestStall) mHave[ch] = 1'b0;
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int ch = 0; ch < 2; ch++) begin
                    mBusy[ch] = 1'b0; mFlushed[ch] = 1'b0; mHave[ch] = 1'b0; mHeld[ch] = 32'h0;
                end
            end else begin
                for (int ch = 0; ch < 2; ch++) modelStep(ch);
            end
        end
    end

    task automatic store(input string n, input logic [3:0] be, input logic [31:0] a, input logic [1:0] sz);
        dataEn = 1'b1; dataWr = 1'b1; dataBe = be; dataAddr = a; dataWdata = 32'hCAFE0000 | a;
        dataMem(1'b1, 1'b1, 32'h0);
        #1;
        check({n, "_size"}, memData.size, sz);
        check({n, "_wr"}, memData.wr, 1'b1);
        check({n, "_stall"}, dataStall, 1'b0);
        tick();
    endtask

    task automatic store64(input string n, input logic [7:0] be, input logic [1:0] sz);
        d64En = 1'b1; d64Wr = 1'b1; d64Be = be;
        #1;
        check({n, "_req"}, memData64.req, 1'b1);
        check({n, "_size"}, memData64.size, sz);
        tick();
    endtask

    initial begin : stim
        rst = 1'b1; longestStall = 1'b0;
        instEn = 1'b0; instCancel = 1'b0; instAddr = 32'h0;
        dataEn = 1'b0; dataWr = 1'b0; dataBe = 4'hF; dataAddr = 32'h0; dataWdata = 32'h0;
        instMem(1'b0, 1'b0, 32'h0); dataMem(1'b0, 1'b0, 32'h0);
        i64En = 1'b0; i64Cancel = 1'b0; i64Addr = 32'h0;
        d64En = 1'b0; d64Wr = 1'b0; d64Be = 8'hFF; d64Addr = 32'h4000; d64Wdata = 64'h0;
        memInst64.addrOk = 1'b0; memInst64.dataOk = 1'b0; memInst64.rdata = 64'h0;
        memData64.addrOk = 1'b0; memData64.dataOk = 1'b0; memData64.rdata = 64'h0;
        repeat (3) tick();

        rst = 1'b0;
        #1;
        check("rst_inst_req", memInst.req, 1'b0);
        check("rst_data_req", memData.req, 1'b0);
        check("rst_inst_stall", instStall, 1'b0);
        tick();
        dataEn = 1'b1; dataAddr = 32'h1000;
        #1;
        check("rst_data_stall_en", dataStall, 1'b1);
        check("rst_data_req_en", memData.req, 1'b1);

        // Single-cycle fetch with bypass
        tick();
        dataEn = 1'b0; instEn = 1'b1; instAddr = 32'hBFC00000;
        instMem(1'b1, 1'b1, 32'h24010001);
        #1;
        check("t1_req", memInst.req, 1'b1);
        check("t1_addr", memInst.addr, 32'hBFC00000);
        check("t1_stall", instStall, 1'b0);
        check("t1_rdata", instRdata, 32'h24010001);
        tick();
        instEn = 1'b0; instMem(1'b0, 1'b0, 32'h0);

        // addr_ok at +1, data_ok at +3
        tick();
        instEn = 1'b1; instAddr = 32'h100; longestStall = 1'b1;
        #1;
        check("t2_c0_req", memInst.req, 1'b1);
        check("t2_c0_stall", instStall, 1'b1);
        tick(); instMem(1'b1, 1'b0, 32'h0); #1;
        check("t2_c1_req", memInst.req, 1'b1);
        check("t2_c1_stall", instStall, 1'b1);
        tick(); instMem(1'b0, 1'b0, 32'h0); #1;
        check("t2_c2_req", memInst.req, 1'b0);
        check("t2_c2_stall", instStall, 1'b1);
        tick(); instMem(1'b0, 1'b1, 32'h11112222); longestStall = 1'b0; #1;
        check("t2_c3_req", memInst.req, 1'b0);
        check("t2_c3_stall", instStall, 1'b0);
        check("t2_c3_rdata", instRdata, 32'h11112222);
        tick();
        instEn = 1'b0; instMem(1'b0, 1'b0, 32'h0);

        // Inst finishes early and must be held while the data load is still outstanding
        tick();
        instEn = 1'b1; instAddr = 32'h104; longestStall = 1'b1;
        dataEn = 1'b1; dataWr = 1'b0; dataBe = 4'hF; dataAddr = 32'h2000;
        dataMem(1'b1, 1'b0, 32'h0);
        #1;
        check("t3_c0_istall", instStall, 1'b1);
        tick(); instMem(1'b1, 1'b1, 32'h33334444); dataMem(1'b0, 1'b0, 32'h0); #1;
        check("t3_c1_istall", instStall, 1'b0);
        check("t3_c1_rdata", instRdata, 32'h33334444);
        tick(); instMem(1'b0, 1'b0, 32'hAAAAAAAA); #1;
        check("t3_c2_rdata_held", instRdata, 32'h33334444);
        check("t3_c2_istall", instStall, 1'b0);
        check("t3_c2_req", memInst.req, 1'b0);
        tick(); #1;
        check("t3_c3_req", memInst.req, 1'b0);
        check("t3_c3_dstall", dataStall, 1'b1);
        tick(); dataMem(1'b0, 1'b1, 32'h55556666); #1;
        check("t3_c4_dstall", dataStall, 1'b0);
        check("t3_c4_drdata", dataRdata, 32'h55556666);
        check("t3_c4_req", memInst.req, 1'b0);
        tick(); dataMem(1'b0, 1'b0, 32'hBBBBBBBB); longestStall = 1'b0; #1;
        check("t3_c5_rdata_held", instRdata, 32'h33334444);
        check("t3_c5_drdata_held", dataRdata, 32'h55556666);
        check("t3_c5_req", memInst.req, 1'b0);
        tick(); instAddr = 32'h108; dataEn = 1'b0; instMem(1'b1, 1'b1, 32'h77778888); #1;
        check("t3_c6_req", memInst.req, 1'b1);
        check("t3_c6_rdata", instRdata, 32'h77778888);
        tick();
        instEn = 1'b0; instMem(1'b0, 1'b0, 32'h0);

        // Flush while waiting; the late response must be dropped before the refetch issues
        tick();
        instEn = 1'b1; instAddr = 32'h200; longestStall = 1'b1; instMem(1'b1, 1'b0, 32'h0);
        #1;
        check("t4_c0_req", memInst.req, 1'b1);
        tick(); instMem(1'b0, 1'b0, 32'h0); instCancel = 1'b1; #1;
        check("t4_c1_stall", instStall, 1'b1);
        tick(); instCancel = 1'b0; instAddr = 32'h80000180; #1;
        check("t4_c2_req", memInst.req, 1'b0);
        check("t4_c2_stall", instStall, 1'b1);
        tick(); instMem(1'b0, 1'b1, 32'hDEADBEEF); #1;
        check("t4_c3_req", memInst.req, 1'b0);
        check("t4_c3_stall", instStall, 1'b1);
        tick(); instMem(1'b1, 1'b1, 32'h401A6000); longestStall = 1'b0; #1;
        check("t4_c4_req", memInst.req, 1'b1);
        check("t4_c4_addr", memInst.addr, 32'h80000180);
        check("t4_c4_rdata", instRdata, 32'h401A6000);
        tick();
        instEn = 1'b0; instMem(1'b0, 1'b0, 32'h0);

        // Store size encoding, 32-bit and 64-bit
        tick();
        store("t5_be3", 4'b0011, 32'h3000, 2'd1);
        store("t5_be8", 4'b1000, 32'h3003, 2'd0);
        store("t5_beF", 4'b1111, 32'h3004, 2'd2);
        dataEn = 1'b0; dataWr = 1'b0; dataMem(1'b0, 1'b0, 32'h0);
        store64("t5_64_F0", 8'hF0, 2'd2);
        store64("t5_64_FF", 8'hFF, 2'd3);
        store64("t5_64_0C", 8'h0C, 2'd1);
        store64("t5_64_01", 8'h01, 2'd0);
        d64En = 1'b0; d64Wr = 1'b0;

        // Reset while waiting; stray data_ok afterwards must not complete anything
        tick();
        instEn = 1'b1; instAddr = 32'h300; longestStall = 1'b1; instMem(1'b1, 1'b0, 32'h0);
        tick(); instMem(1'b0, 1'b0, 32'h0); rst = 1'b1; instEn = 1'b0;
        tick(); rst = 1'b0; instMem(1'b0, 1'b1, 32'h99999999); #1;
        check("t6_c2_req", memInst.req, 1'b0);
        check("t6_c2_stall", instStall, 1'b0);
        tick(); instEn = 1'b1; instAddr = 32'h400; #1;
        check("t6_c3_req", memInst.req, 1'b1);
        check("t6_c3_stall", instStall, 1'b1);
        tick(); instMem(1'b1, 1'b1, 32'h12345678); longestStall = 1'b0; #1;
        check("t6_c4_stall", instStall, 1'b0);
        check("t6_c4_rdata", instRdata, 32'h12345678);
        tick();
        instEn = 1'b0; instMem(1'b0, 1'b0, 32'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
